core_control_scoreboard: RTL

Parametrised hazard scoreboard for the core control unit, the successor to the single-slot stall logic. It tracks up to DEPTH in-flight register/flag writers in a fixed-latency shift register, so a decoded instruction stalls only while a true RAW, flag, or PC hazard is outstanding. It also supports pipeline hold and branch flush. It sits between decode and the control cycle FSM, and drives `stall`, `bubble` and `next_bubble`.

---
 rtl/core_control_scoreboard.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/core_control_scoreboard.sv
// core_control_scoreboard
// Hazard scoreboard between decode and the control cycle FSM. In-flight
// register/flag writers ride a fixed-latency shift register (slot 0 youngest);
// a decoded instruction is held back only while a RAW, flag or PC hazard
// against a valid slot is outstanding. Supports pipeline hold and flush.
module core_control_scoreboard #(
   parameter int DEPTH    = 3,
   parameter int REG_BITS = 4,
   parameter int PC_REG   = 15
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cycle_issue,
   input  logic                          hold,
   input  logic                          flush,
   input  logic                          dec_valid,
   input  logic                          dec_uses_rn,
   input  logic [REG_BITS-1:0]           dec_rn,
   input  logic                          dec_snd_is_imm,
   input  logic [REG_BITS-1:0]           dec_snd_r,
   input  logic                          dec_writeback,
   input  logic [REG_BITS-1:0]           dec_rd,
   input  logic                          dec_update_flags,
   input  logic                          dec_conditional,
   input  logic                          ext_flags_busy,
   output logic                          stall,
   output logic                          next_bubble,
   output logic                          bubble,
   output logic [(2**REG_BITS)-1:0]      pending_mask,
   output logic [$clog2(DEPTH+1)-1:0]    inflight
);

   localparam int MASK_W = 2**REG_BITS;
   localparam int CNT_W  = $clog2(DEPTH+1);
   localparam logic [REG_BITS-1:0] PC_IDX = REG_BITS'(PC_REG);

   // slot state
   logic [DEPTH-1:0]    valid_q, valid_d;
   logic [DEPTH-1:0]    wb_q,    wb_d;
   logic [DEPTH-1:0]    flags_q, flags_d;
   logic [REG_BITS-1:0] rd_q [DEPTH];
   logic [REG_BITS-1:0] rd_d [DEPTH];
   logic                bubble_q, bubble_d;

   // hazard terms
   logic pc_hazard_s;
   logic data_hazard_s;
   logic flags_hazard_s;
   logic any_flags_s;
   logic rn_read_s;
   logic snd_read_s;
   logic accept_s;

   // Operand reads that name the PC conflict with any pending register write.
   assign rn_read_s  = dec_uses_rn;
   assign snd_read_s = !dec_snd_is_imm;

   // Hazard detection over valid slots; all terms are zero-latency.
   always_comb begin
      pc_hazard_s   = 1'b0;
      data_hazard_s = 1'b0;
      any_flags_s   = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         pc_hazard_s   = pc_hazard_s |
                         (valid_q[k] & wb_q[k] & (rd_q[k] == PC_IDX));
         data_hazard_s = data_hazard_s |
                         (valid_q[k] & wb_q[k] &
                          ((rn_read_s  & ((dec_rn    == rd_q[k]) | (dec_rn    == PC_IDX))) |
                           (snd_read_s & ((dec_snd_r == rd_q[k]) | (dec_snd_r == PC_IDX)))));
         any_flags_s   = any_flags_s | (valid_q[k] & flags_q[k]);
      end
      flags_hazard_s = (dec_update_flags | dec_conditional) & (any_flags_s | ext_flags_busy);
      next_bubble    = dec_valid & (pc_hazard_s | data_hazard_s | flags_hazard_s);
      stall          = !cycle_issue | next_bubble | hold;
      accept_s       = cycle_issue & dec_valid & !next_bubble & !hold & !flush;
   end

   // Pending-write mask and occupancy count derived from the slots.
   always_comb begin
      pending_mask = '0;
      inflight     = '0;
      for (int k = 0; k < DEPTH; k++) begin
         pending_mask = pending_mask |
                        (MASK_W'(valid_q[k] & wb_q[k]) << rd_q[k]);
         inflight     = inflight + CNT_W'(valid_q[k]);
      end
   end

   // Next slot/bubble state: flush clears, hold freezes, otherwise shift.
   always_comb begin
      valid_d  = valid_q;
      wb_d     = wb_q;
      flags_d  = flags_q;
      bubble_d = bubble_q;
      for (int k = 0; k < DEPTH; k++) begin
         rd_d[k] = rd_q[k];
      end
      if (flush) begin
         valid_d  = '0;
         wb_d     = '0;
         flags_d  = '0;
         bubble_d = 1'b0;
         for (int k = 0; k < DEPTH; k++) begin
            rd_d[k] = '0;
         end
      end else if (hold) begin
         bubble_d = bubble_q;
      end else begin
         for (int k = 1; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            wb_d[k]    = wb_q[k-1];
            flags_d[k] = flags_q[k-1];
            rd_d[k]    = rd_q[k-1];
         end
         valid_d[0] = accept_s;
         wb_d[0]    = accept_s & dec_writeback;
         flags_d[0] = accept_s & dec_update_flags;
         rd_d[0]    = accept_s ? dec_rd : '0;
         bubble_d   = cycle_issue & next_bubble;
      end
   end

   // State registers with synchronous reset discarding every entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= '0;
         wb_q     <= '0;
         flags_q  <= '0;
         bubble_q <= 1'b0;
         for (int k = 0; k < DEPTH; k++) begin
            rd_q[k] <= '0;
         end
      end else begin
         valid_q  <= valid_d;
         wb_q     <= wb_d;
         flags_q  <= flags_d;
         bubble_q <= bubble_d;
         for (int k = 0; k < DEPTH; k++) begin
            rd_q[k] <= rd_d[k];
         end
      end
   end

   assign bubble = bubble_q;

endmodule
